lsu_dmem_ctrl: RTL and testbench

Load/store unit between the RISC-V core's execute/write-back datapath and a word-wide data memory with a variable-latency request/acknowledge interface.
- Takes the core's ALU address, rs2 store data and funct3.
- Generates word-aligned memory requests with byte enables and lane-replicated store data.
- Returns sign/zero-extended load data for write-back.
- Asserts a stall so the core freezes its PC and register write until the access completes.
- Detects misaligned and illegal accesses.

---
 rtl/lsu_dmem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: RV32I loads/stores to a word-wide, variable-latency data memory.
// Optional BUSY watchdog enabled by defining LSU_TIMEOUT_EN (TIMEOUT_CYCLES, 1..255).
module lsu_dmem_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_FAULT} state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_dmem_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]        cnt_q, cnt_d;
`endif

  logic        illegal, misal;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request classification; illegal encodings outrank misalignment.
  always_comb begin
    illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
              (req_we && req_funct3[2]);
    misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    req_be = 4'b1111;
    req_wd = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          req_be = 4'b0001 << req_addr[1:0];
          req_wd = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          req_be = req_addr[1] ? 4'b1100 : 4'b0011;
          req_wd = {2{req_wdata[15:0]}};
        end
        default: begin
          req_be = 4'b1111;
          req_wd = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          be_d    = req_be;
          wdata_d = req_wd;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (illegal) begin
            cause_d = 2'b10;
            state_d = S_FAULT;
          end else if (misal) begin
            cause_d = 2'b01;
            state_d = S_FAULT;
          end else begin
            cause_d = 2'b00;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = ld_data;
          state_d = S_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          cause_d = 2'b11;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cause_q <= '0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign done        = (state_q == S_RESP) || (state_q == S_FAULT);
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = fault ? cause_q : 2'b00;
  assign stall       = req_valid & ~done;
  assign mem_req     = (state_q == S_BUSY);
  assign mem_we      = mem_req & we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl; timeout path exercised when LSU_TIMEOUT_EN is defined.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  lsu_dmem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    #1;
  endtask

  // Zero-wait load: accept, one BUSY cycle with ack, then the RESP pulse.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    set_req(1'b0, f3, a, 32'h0);
    tick();
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_be"}, 32'(mem_be), 32'hF);
    chk({tag, "_busy_done"}, 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = word;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_rdata"}, rdata, exp_data);
    req_valid = 1'b0;
    tick();
  endtask

  initial begin
    int unsigned scnt;
    int unsigned rcnt;
    int unsigned dcnt;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // LB 0x103: lane 3 = 0x80, sign-extended
    set_req(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb_stall_accept", 32'(stall), 32'd1);
    req_valid = 1'b0; #1;
    do_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0100, 32'hFFFF_FF80);

    // LHU 0x102 with 3 wait cycles
    set_req(1'b0, 3'b101, 32'h0000_0102, 32'h0);
    scnt = 0;
    if (stall) scnt++;
    tick();
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 3); mem_rdata = 32'h8001_0000;
      #1;
      if (stall) scnt++;
      tick();
    end
    mem_ack = 1'b0;
    chk("lhu_done", 32'(done), 32'd1);
    chk("lhu_stall_end", 32'(stall), 32'd0);
    chk("lhu_stall_cycles", scnt, 32'd5);
    chk("lhu_rdata", rdata, 32'h0000_8001);
    req_valid = 1'b0;
    tick();
    chk("lhu_done_pulse", 32'(done), 32'd0);

    do_load("lh", 3'b001, 32'h0000_0100, 32'h1234_8765, 32'h0000_0100, 32'hFFFF_8765);
    do_load("lbu", 3'b100, 32'h0000_0101, 32'h0000_F000, 32'h0000_0100, 32'h0000_00F0);
    do_load("lw", 3'b010, 32'h0000_0208, 32'hCAFE_0001, 32'h0000_0208, 32'hCAFE_0001);

    // SB 0x101
    set_req(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB);
    tick();
    chk("sb_req", 32'(mem_req), 32'd1);
    chk("sb_we", 32'(mem_we), 32'd1);
    chk("sb_be", 32'(mem_be), 32'b0010);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", mem_addr, 32'h0000_0100);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0; req_valid = 1'b0;
    chk("sb_done", 32'(done), 32'd1);
    chk("sb_rdata_kept", rdata, 32'hCAFE_0001);
    tick();

    // SH 0x102 with one wait cycle
    set_req(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234);
    tick();
    tick();
    chk("sh_req_wait", 32'(mem_req), 32'd1);
    chk("sh_be", 32'(mem_be), 32'b1100);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; req_valid = 1'b0;
    chk("sh_done", 32'(done), 32'd1);
    tick();

    // Faults
    set_req(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    tick();
    chk("misal_mem_req", 32'(mem_req), 32'd0);
    chk("misal_done", 32'(done), 32'd1);
    chk("misal_fault", 32'(fault), 32'd1);
    chk("misal_cause", 32'(fault_cause), 32'd1);
    req_valid = 1'b0;
    tick();
    chk("misal_after_done", 32'(done), 32'd0);
    chk("misal_after_cause", 32'(fault_cause), 32'd0);

    set_req(1'b0, 3'b011, 32'h0000_0100, 32'h0);
    tick();
    chk("ill011_fault", 32'(fault), 32'd1);
    chk("ill011_cause", 32'(fault_cause), 32'd2);
    req_valid = 1'b0; tick();

    set_req(1'b0, 3'b111, 32'h0000_0101, 32'h0);
    tick();
    chk("ill_prec_cause", 32'(fault_cause), 32'd2);
    req_valid = 1'b0; tick();

    set_req(1'b1, 3'b100, 32'h0000_0100, 32'h0);
    tick();
    chk("ill_store_cause", 32'(fault_cause), 32'd2);
    chk("ill_store_mem_req", 32'(mem_req), 32'd0);
    req_valid = 1'b0; tick();

    set_req(1'b1, 3'b001, 32'h0000_0103, 32'h0);
    tick();
    chk("sh_misal_cause", 32'(fault_cause), 32'd1);
    req_valid = 1'b0; tick();

    // Reset during BUSY, then a stray ack
    set_req(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    tick(); tick();
    chk("rstbusy_req", 32'(mem_req), 32'd1);
    rst = 1'b1; req_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstbusy_mem_req", 32'(mem_req), 32'd0);
    chk("rstbusy_done", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_done", 32'(done), 32'd0);
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    tick();
    chk("stray_ack_done2", 32'(done), 32'd0);

    set_req(1'b1, 3'b010, 32'h0000_0204, 32'hDEAD_BEEF);
    tick();
    chk("sw_be", 32'(mem_be), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", mem_addr, 32'h0000_0204);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; req_valid = 1'b0;
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_fault", 32'(fault), 32'd0);
    chk("sw_rdata_after_rst", rdata, 32'h0);
    tick();

    // Memory never acknowledges
    set_req(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    tick();
    rcnt = 0; dcnt = 0;
`ifdef LSU_TIMEOUT_EN
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        dcnt++;
        break;
      end
      if (mem_req) rcnt++;
      tick();
    end
    chk("to_req_cycles", rcnt, 32'd4);
    chk("to_done", dcnt, 32'd1);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_cause", 32'(fault_cause), 32'd3);
    req_valid = 1'b0;
    tick();
`else
    for (int c = 0; c < 30; c++) begin
      if (done) dcnt++;
      if (stall) rcnt++;
      tick();
    end
    chk("noto_stall_cycles", rcnt, 32'd30);
    chk("noto_done", dcnt, 32'd0);
    chk("noto_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1; req_valid = 1'b0;
    tick();
    rst = 1'b0;
`endif
    chk("final_idle_req", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
